// File: rtl/rv32i_mem_port_arbiter_pkg.sv
// Shared types and constants for the rv32i memory port arbiter.
// Used by the top module and the priority selector.
package rv32i_mem_port_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LSU   = 2'd2,
    OWN_EXT   = 2'd3
  } owner_t;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  // Width of a counter that must be able to hold the value `limit`.
  function automatic int unsigned starve_cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rv32i_mem_port_arbiter_priority_sel.sv
// Combinational winner selection for the memory port: ext > lsu > fetch,
// with an optional promotion of fetch above lsu (never above ext).
module rv32i_mem_port_arbiter_priority_sel
  import rv32i_mem_port_arbiter_pkg::*;
(
  input  logic       i_fetch_req,
  input  logic       i_fetch_flush,
  input  logic       i_fetch_promote,
  input  logic       i_lsu_req,
  input  logic       i_ext_req,
  output logic [1:0] o_winner
);

  logic   fetch_ok;
  owner_t winner;

  always_comb begin
    // A flush in the same cycle would fetch down the wrong path.
    fetch_ok = i_fetch_req & ~i_fetch_flush;
    winner   = OWN_NONE;
    if (i_ext_req) begin
      winner = OWN_EXT;
    end else if (fetch_ok && i_fetch_promote) begin
      winner = OWN_FETCH;
    end else if (i_lsu_req) begin
      winner = OWN_LSU;
    end else if (fetch_ok) begin
      winner = OWN_FETCH;
    end
  end

  assign o_winner = winner;

endmodule

// File: rtl/rv32i_mem_port_arbiter.sv
// Single-port memory arbiter for fetch, load/store and external program load.
// Define RV32I_ARB_STARVE_GUARD_EN to enable the fetch starvation guard.
module rv32i_mem_port_arbiter
  import rv32i_mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,

  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  input  logic              i_fetch_flush,
  output logic              o_fetch_gnt,
  output logic              o_fetch_rvalid,
  output logic [31:0]       o_fetch_rdata,

  input  logic              i_lsu_req,
  input  logic              i_lsu_we,
  input  logic [ADDR_W-1:0] i_lsu_addr,
  input  logic [31:0]       i_lsu_wdata,
  output logic              o_lsu_gnt,
  output logic              o_lsu_rvalid,
  output logic [31:0]       o_lsu_rdata,

  input  logic              i_ext_req,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [31:0]       i_ext_wdata,
  output logic              o_ext_gnt,
  output logic              o_ext_done,

  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_valid,
  input  logic [31:0]       i_mem_rdata
);

  arb_state_t state;
  owner_t     owner;
  owner_t     winner;
  logic [1:0] winner_raw;
  logic       drop;
  logic       fetch_promote;

  rv32i_mem_port_arbiter_priority_sel u_priority_sel (
    .i_fetch_req     (i_fetch_req),
    .i_fetch_flush   (i_fetch_flush),
    .i_fetch_promote (fetch_promote),
    .i_lsu_req       (i_lsu_req),
    .i_ext_req       (i_ext_req),
    .o_winner        (winner_raw)
  );

  assign winner = owner_t'(winner_raw);

`ifdef RV32I_ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = starve_cnt_width(STARVE_LIMIT);

  logic [CntW-1:0] starve_cnt;
  logic            fetch_lost;

  // Only a grant to another requester counts as a lost arbitration.
  assign fetch_lost    = i_fetch_req && (winner != OWN_FETCH) && (winner != OWN_NONE);
  assign fetch_promote = (32'(starve_cnt) >= STARVE_LIMIT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (winner == OWN_FETCH) begin
        starve_cnt <= '0;
      end else if (fetch_lost && (32'(starve_cnt) < STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign fetch_promote = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      owner          <= OWN_NONE;
      drop           <= 1'b0;
      o_fetch_gnt    <= 1'b0;
      o_fetch_rvalid <= 1'b0;
      o_fetch_rdata  <= '0;
      o_lsu_gnt      <= 1'b0;
      o_lsu_rvalid   <= 1'b0;
      o_lsu_rdata    <= '0;
      o_ext_gnt      <= 1'b0;
      o_ext_done     <= 1'b0;
      o_mem_en       <= 1'b0;
      o_mem_we       <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_wdata    <= '0;
    end else begin
      o_fetch_gnt    <= 1'b0;
      o_lsu_gnt      <= 1'b0;
      o_ext_gnt      <= 1'b0;
      o_fetch_rvalid <= 1'b0;
      o_lsu_rvalid   <= 1'b0;
      o_ext_done     <= 1'b0;

      unique case (state)
        IDLE: begin
          drop <= 1'b0;
          unique case (winner)
            OWN_EXT: begin
              o_ext_gnt   <= 1'b1;
              o_mem_en    <= 1'b1;
              o_mem_we    <= 1'b1;
              o_mem_addr  <= i_ext_addr;
              o_mem_wdata <= i_ext_wdata;
              owner       <= OWN_EXT;
              state       <= BUSY;
            end
            OWN_LSU: begin
              o_lsu_gnt   <= 1'b1;
              o_mem_en    <= 1'b1;
              o_mem_we    <= i_lsu_we;
              o_mem_addr  <= i_lsu_addr;
              o_mem_wdata <= i_lsu_wdata;
              owner       <= OWN_LSU;
              state       <= BUSY;
            end
            OWN_FETCH: begin
              o_fetch_gnt <= 1'b1;
              o_mem_en    <= 1'b1;
              o_mem_we    <= 1'b0;
              o_mem_addr  <= i_fetch_addr;
              owner       <= OWN_FETCH;
              state       <= BUSY;
            end
            default: begin
              owner <= OWN_NONE;
            end
          endcase
        end

        BUSY: begin
          if ((owner == OWN_FETCH) && i_fetch_flush) begin
            drop <= 1'b1;
          end
          if (i_mem_valid) begin
            o_mem_en <= 1'b0;
            o_mem_we <= 1'b0;
            owner    <= OWN_NONE;
            drop     <= 1'b0;
            state    <= IDLE;
            case (owner)
              OWN_FETCH: begin
                // A flush landing on the completion cycle also kills the response.
                if (!(drop || i_fetch_flush)) begin
                  o_fetch_rvalid <= 1'b1;
                  o_fetch_rdata  <= i_mem_rdata;
                end
              end
              OWN_LSU: begin
                o_lsu_rvalid <= 1'b1;
                if (!o_mem_we) begin
                  o_lsu_rdata <= i_mem_rdata;
                end
              end
              OWN_EXT: begin
                o_ext_done <= 1'b1;
              end
              default: begin
                o_ext_done <= 1'b0;
              end
            endcase
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_port_arbiter.sv
// Self-checking bench for rv32i_mem_port_arbiter with a variable-latency memory
// model and a response scoreboard.
module tb_rv32i_mem_port_arbiter;

  localparam int unsigned AW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_fetch_req, i_fetch_flush;
  logic [AW-1:0] i_fetch_addr;
  logic          o_fetch_gnt, o_fetch_rvalid;
  logic [31:0]   o_fetch_rdata;
  logic          i_lsu_req, i_lsu_we;
  logic [AW-1:0] i_lsu_addr;
  logic [31:0]   i_lsu_wdata;
  logic          o_lsu_gnt, o_lsu_rvalid;
  logic [31:0]   o_lsu_rdata;
  logic          i_ext_req;
  logic [AW-1:0] i_ext_addr;
  logic [31:0]   i_ext_wdata;
  logic          o_ext_gnt, o_ext_done;
  logic          o_mem_en, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic          i_mem_valid;
  logic [31:0]   i_mem_rdata;

  rv32i_mem_port_arbiter #(
    .STARVE_LIMIT (4),
    .ADDR_W       (AW)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_fetch_req    (i_fetch_req),
    .i_fetch_addr   (i_fetch_addr),
    .i_fetch_flush  (i_fetch_flush),
    .o_fetch_gnt    (o_fetch_gnt),
    .o_fetch_rvalid (o_fetch_rvalid),
    .o_fetch_rdata  (o_fetch_rdata),
    .i_lsu_req      (i_lsu_req),
    .i_lsu_we       (i_lsu_we),
    .i_lsu_addr     (i_lsu_addr),
    .i_lsu_wdata    (i_lsu_wdata),
    .o_lsu_gnt      (o_lsu_gnt),
    .o_lsu_rvalid   (o_lsu_rvalid),
    .o_lsu_rdata    (o_lsu_rdata),
    .i_ext_req      (i_ext_req),
    .i_ext_addr     (i_ext_addr),
    .i_ext_wdata    (i_ext_wdata),
    .o_ext_gnt      (o_ext_gnt),
    .o_ext_done     (o_ext_done),
    .o_mem_en       (o_mem_en),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_valid    (i_mem_valid),
    .i_mem_rdata    (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge i_clk) cyc++;

  // Memory model: completion visible `lat` cycles after o_mem_en first rises.
  int          lat = 2;
  int          mcnt = 0;
  logic        model_valid = 1'b0;
  logic [31:0] model_rdata = '0;
  logic        force_valid = 1'b0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;

  assign i_mem_valid = model_valid | force_valid;
  assign i_mem_rdata = ovr_en ? ovr_val : model_rdata;

  function automatic logic [31:0] rd_model(input logic [31:0] addr);
    return 32'hDEADBEEF ^ (addr - 32'h10);
  endfunction

  always @(negedge i_clk) begin
    if (model_valid) begin
      model_valid = 1'b0;
      mcnt        = 0;
    end else if (o_mem_en) begin
      if (mcnt >= lat - 1) begin
        model_valid = 1'b1;
        model_rdata = rd_model(o_mem_addr);
      end else begin
        mcnt++;
      end
    end else begin
      mcnt = 0;
    end
  end

  // Scoreboard: kind 1 = fetch, 2 = lsu, 3 = ext.
  typedef struct {
    int          kind;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb_e;
  logic [2:0]  resp_v;
  logic [31:0] resp_d[3];

  always @(negedge i_clk) begin
    resp_v    = {o_ext_done, o_lsu_rvalid, o_fetch_rvalid};
    resp_d[0] = o_fetch_rdata;
    resp_d[1] = o_lsu_rdata;
    resp_d[2] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      if (resp_v[k]) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: kind %0d response at cycle %0d, none expected", k + 1,
                   cyc);
        end else begin
          sb_e = sb.pop_front();
          if (sb_e.kind != k + 1 || (sb_e.chk && resp_d[k] !== sb_e.data)) begin
            n_fail++;
            $display("FAIL sb_resp: got kind %0d data %h, expected kind %0d data %h", k + 1,
                     resp_d[k], sb_e.kind, sb_e.data);
          end
        end
      end
    end
  end

  task automatic wait_gnt(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if ((which == 1 && o_fetch_gnt) || (which == 2 && o_lsu_gnt) ||
          (which == 3 && o_ext_gnt)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge i_clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_fetch_req = 1'b1; i_fetch_addr = 32'h4; i_fetch_flush = 1'b0;
    i_lsu_req = 1'b1; i_lsu_we = 1'b1; i_lsu_addr = 32'h8; i_lsu_wdata = 32'h1;
    i_ext_req = 1'b0; i_ext_addr = '0; i_ext_wdata = '0;
    repeat (3) @(negedge i_clk);
    n_checks += 5;
    if ({o_fetch_gnt, o_lsu_gnt, o_ext_gnt, o_fetch_rvalid, o_lsu_rvalid, o_ext_done,
         o_mem_en, o_mem_we} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, expected 0", {o_fetch_gnt, o_lsu_gnt,
               o_ext_gnt, o_fetch_rvalid, o_lsu_rvalid, o_ext_done, o_mem_en, o_mem_we});
    end
    if (o_mem_addr !== '0) begin
      n_fail++; $display("FAIL reset_addr: got %h, expected 0", o_mem_addr);
    end
    if (o_mem_wdata !== '0) begin
      n_fail++; $display("FAIL reset_wdata: got %h, expected 0", o_mem_wdata);
    end
    if (o_fetch_rdata !== '0) begin
      n_fail++; $display("FAIL reset_fetch_rdata: got %h, expected 0", o_fetch_rdata);
    end
    if (o_lsu_rdata !== '0) begin
      n_fail++; $display("FAIL reset_lsu_rdata: got %h, expected 0", o_lsu_rdata);
    end
    i_fetch_req = 1'b0; i_lsu_req = 1'b0; i_lsu_we = 1'b0;
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_fetch_single();
    bit ok;
    bit held;
    int g, r;
    lat = 2;
    i_fetch_req = 1'b1; i_fetch_addr = 32'h10;
    sb.push_back('{kind: 1, data: 32'hDEADBEEF, chk: 1'b1});
    wait_gnt(1, ok);
    g = cyc;
    i_fetch_req = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL fetch_gnt: no grant within 20 cycles, expected one");
      return;
    end
    n_checks++;
    if (o_mem_en !== 1'b1 || o_mem_we !== 1'b0 || o_mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL fetch_cmd: en %b we %b addr %h, expected 1 0 00000010",
                         o_mem_en, o_mem_we, o_mem_addr);
    end
    held = 1'b1;
    r = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (o_fetch_rvalid) begin
        r = cyc;
        break;
      end
      if (o_mem_en !== 1'b1 || o_mem_addr !== 32'h10) held = 1'b0;
    end
    n_checks += 2;
    if (!held) begin
      n_fail++; $display("FAIL fetch_hold: command changed before completion, expected held");
    end
    if (r - g != 2) begin
      n_fail++; $display("FAIL fetch_latency: rvalid %0d cycles after gnt, expected 2", r - g);
    end
    @(negedge i_clk);
    n_checks++;
    if (o_fetch_rvalid !== 1'b0 || o_fetch_rdata !== 32'hDEADBEEF || o_mem_en !== 1'b0) begin
      n_fail++; $display("FAIL fetch_after: rvalid %b rdata %h en %b, expected 0 deadbeef 0",
                         o_fetch_rvalid, o_fetch_rdata, o_mem_en);
    end
    drain("fetch_single");
  endtask

  task automatic test_priority();
    int order[3];
    int gcyc[3];
    int rcyc[3];
    int ng = 0;
    int nr = 0;
    lat = 3;
    i_ext_req = 1'b1; i_ext_addr = 32'h80; i_ext_wdata = 32'h11112222;
    i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = 32'h44;
    i_fetch_req = 1'b1; i_fetch_addr = 32'h20;
    sb.push_back('{kind: 3, data: 32'h0, chk: 1'b0});
    sb.push_back('{kind: 2, data: rd_model(32'h44), chk: 1'b1});
    sb.push_back('{kind: 1, data: rd_model(32'h20), chk: 1'b1});
    for (int i = 0; i < 60 && nr < 3; i++) begin
      @(negedge i_clk);
      if (ng < 3 && (o_ext_gnt || o_lsu_gnt || o_fetch_gnt)) begin
        order[ng] = o_ext_gnt ? 3 : (o_lsu_gnt ? 2 : 1);
        gcyc[ng]  = cyc;
        ng++;
        if (o_ext_gnt) begin
          i_ext_req = 1'b0;
          n_checks++;
          if (o_mem_we !== 1'b1 || o_mem_wdata !== 32'h11112222 || o_mem_addr !== 32'h80) begin
            n_fail++; $display("FAIL prio_ext_cmd: we %b wdata %h addr %h, expected 1 11112222 80",
                               o_mem_we, o_mem_wdata, o_mem_addr);
          end
        end
        if (o_lsu_gnt) i_lsu_req = 1'b0;
        if (o_fetch_gnt) i_fetch_req = 1'b0;
      end
      if (nr < 3 && (o_ext_done || o_lsu_rvalid || o_fetch_rvalid)) begin
        rcyc[nr] = cyc;
        nr++;
      end
    end
    i_ext_req = 1'b0; i_lsu_req = 1'b0; i_fetch_req = 1'b0;
    n_checks++;
    if (ng != 3 || nr != 3) begin
      n_fail++; $display("FAIL prio_count: %0d grants %0d responses, expected 3 and 3", ng, nr);
      return;
    end
    n_checks += 3;
    if (order[0] != 3 || order[1] != 2 || order[2] != 1) begin
      n_fail++; $display("FAIL prio_order: got %0d %0d %0d, expected 3 2 1", order[0], order[1],
                         order[2]);
    end
    if (gcyc[1] != rcyc[0] + 1) begin
      n_fail++; $display("FAIL prio_gap1: grant at %0d, expected %0d", gcyc[1], rcyc[0] + 1);
    end
    if (gcyc[2] != rcyc[1] + 1) begin
      n_fail++; $display("FAIL prio_gap2: grant at %0d, expected %0d", gcyc[2], rcyc[1] + 1);
    end
    drain("priority");
  endtask

  task automatic test_flush();
    bit ok;
    bit seen;
    // Flush while BUSY drops the response.
    lat = 3; ovr_en = 1'b1; ovr_val = 32'h13;
    i_fetch_req = 1'b1; i_fetch_addr = 32'h30;
    wait_gnt(1, ok);
    i_fetch_req = 1'b0;
    @(negedge i_clk);
    i_fetch_flush = 1'b1;
    @(negedge i_clk);
    i_fetch_flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && o_mem_en; i++) begin
      @(negedge i_clk);
      if (o_fetch_rvalid) seen = 1'b1;
    end
    @(negedge i_clk);
    if (o_fetch_rvalid) seen = 1'b1;
    ovr_en = 1'b0;
    n_checks += 2;
    if (!ok || seen) begin
      n_fail++; $display("FAIL flush_busy: gnt %b rvalid_seen %b, expected 1 0", ok, seen);
    end
    if (o_mem_en !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: mem_en %b, expected 0", o_mem_en);
    end
    // Next fetch after the drop proceeds normally.
    lat = 2;
    i_fetch_req = 1'b1; i_fetch_addr = 32'h34;
    sb.push_back('{kind: 1, data: rd_model(32'h34), chk: 1'b1});
    wait_gnt(1, ok);
    i_fetch_req = 1'b0;
    n_checks++;
    if (!ok || o_mem_addr !== 32'h34) begin
      n_fail++; $display("FAIL flush_next: gnt %b addr %h, expected 1 00000034", ok, o_mem_addr);
    end
    drain("flush_next");
    // Flush in IDLE blocks the fetch grant for that cycle only.
    i_fetch_req = 1'b1; i_fetch_addr = 32'h38; i_fetch_flush = 1'b1;
    @(negedge i_clk);
    i_fetch_flush = 1'b0;
    n_checks++;
    if (o_fetch_gnt !== 1'b0 || o_mem_en !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_block: gnt %b en %b, expected 0 0", o_fetch_gnt,
                         o_mem_en);
    end
    sb.push_back('{kind: 1, data: rd_model(32'h38), chk: 1'b1});
    wait_gnt(1, ok);
    i_fetch_req = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL flush_idle_regrant: no grant, expected grant");
    end
    drain("flush_idle");
    // Flush coinciding with completion drops the response.
    lat = 1;
    i_fetch_req = 1'b1; i_fetch_addr = 32'h3C;
    wait_gnt(1, ok);
    i_fetch_req = 1'b0;
    i_fetch_flush = 1'b1;
    @(negedge i_clk);
    i_fetch_flush = 1'b0;
    seen = o_fetch_rvalid;
    @(negedge i_clk);
    seen = seen | o_fetch_rvalid;
    n_checks++;
    if (!ok || seen || o_mem_en !== 1'b0) begin
      n_fail++; $display("FAIL flush_coincide: gnt %b rvalid_seen %b en %b, expected 1 0 0", ok,
                         seen, o_mem_en);
    end
  endtask

  task automatic test_lsu_write();
    bit ok;
    lat = 2;
    i_lsu_req = 1'b1; i_lsu_we = 1'b1; i_lsu_addr = 32'h40; i_lsu_wdata = 32'hA5A5A5A5;
    sb.push_back('{kind: 2, data: 32'h0, chk: 1'b0});
    wait_gnt(2, ok);
    i_lsu_req = 1'b0; i_lsu_we = 1'b0;
    n_checks++;
    if (!ok || o_mem_en !== 1'b1 || o_mem_we !== 1'b1 || o_mem_addr !== 32'h40 ||
        o_mem_wdata !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL lsu_write_cmd: gnt %b en %b we %b addr %h wdata %h, expected 1 1 1 40 a5a5a5a5",
                         ok, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata);
    end
    drain("lsu_write");
  endtask

  task automatic test_idle_valid();
    bit seen;
    force_valid = 1'b1;
    @(negedge i_clk);
    force_valid = 1'b0;
    seen = o_fetch_rvalid | o_lsu_rvalid | o_ext_done;
    @(negedge i_clk);
    seen = seen | o_fetch_rvalid | o_lsu_rvalid | o_ext_done;
    n_checks++;
    if (seen || o_mem_en !== 1'b0) begin
      n_fail++; $display("FAIL idle_valid: response_seen %b en %b, expected 0 0", seen, o_mem_en);
    end
  endtask

  task automatic test_starve();
    int narb = 0;
    int fpos = 0;
    lat = 1;
    i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = 32'h50;
    i_fetch_req = 1'b1; i_fetch_addr = 32'h60;
    for (int i = 0; i < 80 && narb < 8; i++) begin
      @(negedge i_clk);
      if (o_lsu_gnt) begin
        narb++;
        sb.push_back('{kind: 2, data: rd_model(32'h50), chk: 1'b1});
      end
      if (o_fetch_gnt) begin
        narb++;
        fpos = narb;
        i_fetch_req = 1'b0;
        sb.push_back('{kind: 1, data: rd_model(32'h60), chk: 1'b1});
      end
    end
    i_lsu_req = 1'b0; i_fetch_req = 1'b0;
    n_checks++;
`ifdef RV32I_ARB_STARVE_GUARD_EN
    if (fpos != 5) begin
      n_fail++; $display("FAIL starve_guard: fetch won arbitration %0d, expected 5", fpos);
    end
`else
    if (fpos != 0) begin
      n_fail++; $display("FAIL starve_fixed: fetch won arbitration %0d, expected never (0)", fpos);
    end
`endif
    drain("starve");
  endtask

  task automatic test_reset_busy();
    bit ok;
    bit seen = 1'b0;
    lat = 4;
    i_fetch_req = 1'b1; i_fetch_addr = 32'h70;
    wait_gnt(1, ok);
    i_fetch_req = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    repeat (2) begin
      @(negedge i_clk);
      seen = seen | o_fetch_rvalid | o_lsu_rvalid | o_ext_done;
    end
    i_rst_n = 1'b1;
    force_valid = 1'b1;
    @(negedge i_clk);
    force_valid = 1'b0;
    seen = seen | o_fetch_rvalid | o_lsu_rvalid | o_ext_done;
    @(negedge i_clk);
    seen = seen | o_fetch_rvalid | o_lsu_rvalid | o_ext_done;
    n_checks += 2;
    if (!ok || seen) begin
      n_fail++; $display("FAIL reset_busy_resp: gnt %b response_seen %b, expected 1 0", ok, seen);
    end
    if ({o_fetch_gnt, o_lsu_gnt, o_ext_gnt, o_mem_en, o_mem_we} !== 5'b0 ||
        o_mem_addr !== '0 || o_mem_wdata !== '0 || o_fetch_rdata !== '0 ||
        o_lsu_rdata !== '0) begin
      n_fail++; $display("FAIL reset_busy_outs: en %b addr %h wdata %h frd %h lrd %h, expected all 0",
                         o_mem_en, o_mem_addr, o_mem_wdata, o_fetch_rdata, o_lsu_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_single();
    test_priority();
    test_flush();
    test_lsu_write();
    test_idle_valid();
    test_starve();
    test_reset_busy();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: %0d responses outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_port_arbiter.md
RV32I_MEM_PORT_ARBITER -- requirements
Module: rv32I_mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive lost arbitrations after which fetch is promoted to top priority.
REQ-002 Parameter ADDR_W, default 32: address width of all requester and memory ports.
REQ-003 i_clk  input  1  sole clock; all state updates on posedge.
REQ-004 i_rst_n  input  1  reset; synchronous and active-low.
REQ-005 i_fetch_req / i_fetch_addr  input  1 / ADDR_W  fetch read request and word address.
REQ-006 o_fetch_gnt / o_fetch_rvalid / o_fetch_rdata  output  1 / 1 / 32  fetch grant pulse, response valid pulse, read data.
REQ-007 i_fetch_flush  input  1  branch-miss flush; discards any outstanding fetch response.
REQ-008 i_lsu_req / i_lsu_we / i_lsu_addr / i_lsu_wdata  input  1 / 1 / ADDR_W / 32  load-store request.
REQ-009 o_lsu_gnt / o_lsu_rvalid / o_lsu_rdata  output  1 / 1 / 32  lsu grant pulse, completion pulse (reads and writes), read data.
REQ-010 i_ext_req / i_ext_addr / i_ext_wdata  input  1 / ADDR_W / 32  external program-load write request.
REQ-011 o_ext_gnt / o_ext_done  output  1 / 1  external grant pulse and write-complete pulse.
REQ-012 o_mem_en / o_mem_we / o_mem_addr / o_mem_wdata  output  1 / 1 / ADDR_W / 32  single-port memory command.
REQ-013 i_mem_valid / i_mem_rdata  input  1 / 32  memory completion (variable latency >= 1 cycle) and read data.

Function
REQ-014 FSM states: IDLE, BUSY; arbitration occurs only in IDLE, with at most one transaction outstanding.
REQ-015 IDLE with any request: same cycle, assert the winner's gnt for one cycle, drive o_mem_en=1 with its command, register owner, move to BUSY.
REQ-016 Base priority: ext > lsu > fetch.
REQ-017 o_mem_en, o_mem_we, o_mem_addr, and o_mem_wdata are held stable from grant until i_mem_valid.
REQ-018 BUSY with i_mem_valid=1: pulse the owner's response (rvalid with rdata = i_mem_rdata, or o_ext_done), deassert o_mem_en, return to IDLE; the next grant occurs no earlier than the following cycle.
REQ-019 i_mem_valid in IDLE is ignored and produces no response.
REQ-020 i_fetch_flush while fetch owns BUSY: set a drop flag; on completion, suppress o_fetch_rvalid and still return to IDLE.
REQ-021 i_fetch_flush in IDLE: block a fetch grant that cycle; lsu and ext may still be granted.
REQ-022 A flush that coincides with i_mem_valid for a fetch drops that response.
REQ-023 lsu write: o_mem_we=1; o_lsu_rvalid pulses on completion, with o_lsu_rdata don't-care.
REQ-024 An ext write is never preempted; requests arriving while BUSY wait, with requesters holding req until gnt.
REQ-025 Response data outputs hold their last value when not valid.

Reset
REQ-026 While i_rst_n=0 at posedge: state is set to IDLE; all gnt, rvalid, o_ext_done, o_mem_en, and o_mem_we are set to 0; o_mem_addr, o_mem_wdata, and rdata are set to 0; the drop flag and starve counter are cleared.
REQ-027 Reset asserted in BUSY abandons the transaction with no response pulse; a late i_mem_valid after reset is ignored per REQ-019.

Configuration
REQ-028 Macro RV32I_ARB_STARVE_GUARD_EN defined: a saturating counter increments each IDLE arbitration in which fetch requests and loses, and clears on a fetch grant.
REQ-029 With RV32I_ARB_STARVE_GUARD_EN defined, a counter value >= STARVE_LIMIT places fetch above lsu, but never above ext.
REQ-030 Macro RV32I_ARB_STARVE_GUARD_EN undefined: fixed priority per REQ-016, with no counter logic present.

Structure
REQ-031 A shared package (rv32I_pkg) holds the arb_state_t enum (IDLE, BUSY), the owner_t enum (OWN_NONE, OWN_FETCH, OWN_LSU, OWN_EXT), and the default STARVE_LIMIT constant.
REQ-032 The priority/starve selection is one combinational sub-module, rv32I_arb_priority_sel; the FSM and datapath registers stay in the top module.

Verification
REQ-033 Fetch alone, addr 0x10, memory latency 2 -> o_fetch_gnt at cycle 0, o_mem_addr=0x10 held, o_fetch_rvalid with rdata=0xDEADBEEF at cycle 2.
REQ-034 ext, lsu, and fetch all requesting simultaneously -> grant order ext, lsu, fetch, with each grant one cycle after the previous completion.
REQ-035 Fetch granted, i_fetch_flush pulsed in BUSY, memory returns 0x13 -> no o_fetch_rvalid; FSM in IDLE; next fetch to new address granted.
REQ-036 lsu write addr 0x40 data 0xA5A5A5A5 -> o_mem_we=1, o_mem_wdata=0xA5A5A5A5, o_lsu_rvalid on i_mem_valid.
REQ-037 Guard enabled, STARVE_LIMIT=4, lsu and fetch requesting continuously -> fetch granted on the 5th arbitration; guard disabled -> fetch never granted.
REQ-038 Reset asserted mid-BUSY, then i_mem_valid -> no response pulses; all outputs 0.
